// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared states, HD44780 opcodes and helpers for the LCD frame sequencer
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT,
    IDLE,
    FRAME_START,
    ADDR,
    CHAR
  } ctrl_state_t;

  typedef enum logic [2:0] {
    PHY_IDLE,
    PHY_SETUP,
    PHY_EN,
    PHY_WAIT,
    PHY_DONE
  } phy_state_t;

  localparam logic [7:0] FUNC_SET    = 8'h38;
  localparam logic [7:0] DISP_ON     = 8'h0C;
  localparam logic [7:0] ENTRY       = 8'h06;
  localparam logic [7:0] CLEAR       = 8'h01;
  localparam logic [7:0] DDRAM_SET   = 8'h80;
  localparam logic [7:0] LINE_BASE0  = 8'h00;
  localparam logic [7:0] LINE_BASE1  = 8'h40;
  localparam logic [7:0] LINE_BASE2  = 8'h10;
  localparam logic [7:0] LINE_BASE3  = 8'h50;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  function automatic int max5(input int a, input int b, input int c, input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

  function automatic logic [7:0] line_base(input logic [1:0] l);
    case (l)
      2'd0:    return LINE_BASE0;
      2'd1:    return LINE_BASE1;
      2'd2:    return LINE_BASE2;
      default: return LINE_BASE3;
    endcase
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return FUNC_SET;
      2'd1:    return DISP_ON;
      2'd2:    return ENTRY;
      default: return CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_frame_sequencer_if.sv
// rtl/lcd_frame_sequencer_if.sv - HD44780 8-bit write-only panel bus
interface lcd_frame_sequencer_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;

  modport master (output lcd_rs, output lcd_rw, output lcd_en, output lcd_data);
  modport slave  (input  lcd_rs, input  lcd_rw, input  lcd_en, input  lcd_data);
endinterface

// File: rtl/lcd_write_phy.sv
// rtl/lcd_write_phy.sv - one HD44780 byte write: setup, E strobe, settle wait, done pulse
module lcd_write_phy
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC      = 2,
  parameter int EN_CYC         = 25,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 80000,
  parameter int CNT_W          = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   rs,
  input  logic [7:0]             data,
  input  logic                   long,
  output logic                   done,
  lcd_frame_sequencer_if.master  lcd
);

  phy_state_t       state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wait_last;
  logic             long_q;
  logic             rs_q;
  logic [7:0]       data_q;
  logic             en_q;

  assign wait_last = long_q ? CNT_W'(CLEAR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);

  always_comb begin
    next_state = state;
    case (state)
      PHY_IDLE:  if (start) next_state = PHY_SETUP;
      PHY_SETUP: if (cnt == CNT_W'(SETUP_CYC - 1)) next_state = PHY_EN;
      PHY_EN:    if (cnt == CNT_W'(EN_CYC - 1)) next_state = PHY_WAIT;
      PHY_WAIT:  if (cnt == wait_last) next_state = PHY_DONE;
      PHY_DONE:  next_state = PHY_IDLE;
      default:   next_state = PHY_IDLE;
    endcase
  end

  // E is registered from the next state so it exactly tracks PHY_EN without decode glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= PHY_IDLE;
      cnt    <= '0;
      long_q <= 1'b0;
      rs_q   <= 1'b0;
      data_q <= 8'h00;
      en_q   <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= (next_state != state) ? '0 : cnt + 1'b1;
      en_q  <= (next_state == PHY_EN);
      if (state == PHY_IDLE && start) begin
        rs_q   <= rs;
        data_q <= data;
        long_q <= long;
      end
    end
  end

  assign done         = (state == PHY_DONE);
  assign lcd.lcd_rs   = rs_q;
  assign lcd.lcd_rw   = 1'b0;
  assign lcd.lcd_en   = en_q;
  assign lcd.lcd_data = data_q;

endmodule

// File: rtl/lcd_frame_sequencer.sv
// rtl/lcd_frame_sequencer.sv - LCD power-on init and 16x4 frame streaming controller
module lcd_frame_sequencer
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC    = 750000,
  parameter int SETUP_CYC      = 2,
  parameter int EN_CYC         = 25,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 80000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [127:0]           line0,
  input  logic [127:0]           line1,
  input  logic [127:0]           line2,
  input  logic [127:0]           line3,
  input  logic                   refresh,
  output logic                   busy,
  output logic                   init_done,
  lcd_frame_sequencer_if.master  lcd
);

  localparam int CNT_W = $clog2(max5(POWERUP_CYC, SETUP_CYC, EN_CYC,
                                     CMD_WAIT_CYC, CLEAR_WAIT_CYC)) + 1;

  ctrl_state_t      state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       col;
  logic [1:0]       line;
  logic             pending;
  logic             init_done_q;
  logic             issued;
  logic [127:0]     frame [4];

  logic             start;
  logic             wr_rs;
  logic [7:0]       wr_data;
  logic             wr_long;
  logic             done;
  logic [127:0]     cur_line;
  logic [6:0]       ch_lo;
  logic [7:0]       ch;
  logic             redraw;

  // col c lives at bits [127-8c -: 8], i.e. low bit 8*(15-c) = {~c, 3'b0}
  assign cur_line = frame[line];
  assign ch_lo    = {~col, 3'b000};
  assign ch       = cur_line[ch_lo +: 8];
  assign redraw   = pending || refresh;

  always_comb begin
    next_state = state;
    start      = 1'b0;
    wr_rs      = 1'b0;
    wr_data    = 8'h00;
    wr_long    = 1'b0;
    case (state)
      PWR_WAIT: if (cnt == CNT_W'(POWERUP_CYC - 1)) next_state = INIT;
      INIT: begin
        start   = !issued;
        wr_data = init_cmd(col[1:0]);
        wr_long = (col[1:0] == 2'd3);
        if (done && col[1:0] == 2'd3) next_state = redraw ? FRAME_START : IDLE;
      end
      IDLE:        if (refresh) next_state = FRAME_START;
      FRAME_START: next_state = ADDR;
      ADDR: begin
        start   = !issued;
        wr_data = DDRAM_SET | line_base(line);
        if (done) next_state = CHAR;
      end
      CHAR: begin
        start   = !issued;
        wr_rs   = 1'b1;
        wr_data = (ch == 8'h00) ? ASCII_SPACE : ch;
        if (done && col == 4'd15) begin
          if (line == 2'd3) next_state = redraw ? FRAME_START : IDLE;
          else              next_state = ADDR;
        end
      end
      default: next_state = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PWR_WAIT;
      cnt         <= '0;
      col         <= 4'd0;
      line        <= 2'd0;
      pending     <= 1'b0;
      init_done_q <= 1'b0;
      issued      <= 1'b0;
      frame[0]    <= '0;
      frame[1]    <= '0;
      frame[2]    <= '0;
      frame[3]    <= '0;
    end else begin
      state <= next_state;

      if (state == PWR_WAIT) cnt <= (next_state == PWR_WAIT) ? cnt + 1'b1 : '0;

      if (start)     issued <= 1'b1;
      else if (done) issued <= 1'b0;

      // a request landing on the snapshot clock still earns its own frame
      if (state == FRAME_START)                pending <= refresh;
      else if (refresh && state != IDLE)       pending <= 1'b1;

      case (state)
        INIT: if (done) begin
          if (col[1:0] == 2'd3) begin
            col         <= 4'd0;
            init_done_q <= 1'b1;
          end else begin
            col <= col + 4'd1;
          end
        end
        FRAME_START: begin
          frame[0] <= line0;
          frame[1] <= line1;
          frame[2] <= line2;
          frame[3] <= line3;
          line     <= 2'd0;
          col      <= 4'd0;
        end
        ADDR: if (done) col <= 4'd0;
        CHAR: if (done) begin
          if (col == 4'd15) line <= line + 2'd1;
          col <= col + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign init_done = init_done_q;

  lcd_write_phy #(
    .SETUP_CYC      (SETUP_CYC),
    .EN_CYC         (EN_CYC),
    .CMD_WAIT_CYC   (CMD_WAIT_CYC),
    .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC),
    .CNT_W          (CNT_W)
  ) u_phy (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .rs    (wr_rs),
    .data  (wr_data),
    .long  (wr_long),
    .done  (done),
    .lcd   (lcd)
  );

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// tb/tb_lcd_frame_sequencer.sv - directed bench for the LCD frame sequencer
module tb_lcd_frame_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] line0, line1, line2, line3;
  logic         refresh;
  logic         busy, init_done;

  lcd_frame_sequencer_if lcd ();

  lcd_frame_sequencer #(
    .POWERUP_CYC    (20),
    .SETUP_CYC      (2),
    .EN_CYC         (3),
    .CMD_WAIT_CYC   (8),
    .CLEAR_WAIT_CYC (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .line0     (line0),
    .line1     (line1),
    .line2     (line2),
    .line3     (line3),
    .refresh   (refresh),
    .busy      (busy),
    .init_done (init_done),
    .lcd       (lcd)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [8:0] wr_q [$];
  logic       en_prev = 1'b0;

  // capture {rs, data} on every rising edge of E
  always @(negedge clk) begin
    if (lcd.lcd_en === 1'b1 && en_prev !== 1'b1) wr_q.push_back({lcd.lcd_rs, lcd.lcd_data});
    en_prev = lcd.lcd_en;
  end

  logic [7:0] init_exp [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
  logic [7:0] addr_exp [4] = '{8'h80, 8'hC0, 8'h90, 8'hD0};
  logic [7:0] line0_exp [16] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h41, 8'h44, 8'h44, 8'h20,
                                 8'h52, 8'h31, 8'h20, 8'h2B, 8'h20, 8'h52, 8'h32, 8'h3A};

  task automatic wait_writes(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (wr_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_refresh();
    @(negedge clk) refresh = 1'b1;
    @(negedge clk) refresh = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output int writes_at_idle);
    writes_at_idle = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        writes_at_idle = wr_q.size();
        break;
      end
    end
  endtask

  task automatic test_reset();
    int  bad;
    int  gap;
    bit  ok;
    rst = 1'b1; refresh = 1'b0;
    line0 = '0; line1 = '0; line2 = '0; line3 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (lcd.lcd_en !== 1'b0 || lcd.lcd_rs !== 1'b0 || lcd.lcd_rw !== 1'b0 || lcd.lcd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_bus: en=%b rs=%b rw=%b data=%h, required 0 0 0 00",
               lcd.lcd_en, lcd.lcd_rs, lcd.lcd_rw, lcd.lcd_data);
    end
    checks++;
    if (busy !== 1'b1 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: busy=%b init_done=%b, required 1 0", busy, init_done);
    end
    wr_q.delete();
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (lcd.lcd_en !== 1'b0 || lcd.lcd_data !== 8'h00 || lcd.lcd_rs !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL powerup_hold: %0d of 20 clocks left reset values, required 0", bad);
    end
    wait_writes(4, 300, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL init_timeout: saw %0d writes, required 4", wr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_q[i] !== {1'b0, init_exp[i]}) begin
          errors++;
          $display("FAIL init_cmd%0d: rs/data=%h, required %h", i, wr_q[i], {1'b0, init_exp[i]});
        end
      end
      for (int k = 0; k < 100 && lcd.lcd_en === 1'b1; k++) @(negedge clk);
      gap = 0;
      for (int k = 0; k < 200; k++) begin
        if (init_done === 1'b1) break;
        gap++;
        @(negedge clk);
      end
      // 16 clear-wait clocks plus the done clock
      checks++;
      if (gap != 17) begin
        errors++;
        $display("FAIL clear_gap: E-low clocks before init_done=%0d, required 17", gap);
      end
    end
    @(negedge clk);
    checks++;
    if (init_done !== 1'b1 || busy !== 1'b0 || wr_q.size() != 4) begin
      errors++;
      $display("FAIL init_end: init_done=%b busy=%b writes=%0d, required 1 0 4",
               init_done, busy, wr_q.size());
    end
  endtask

  task automatic test_frame();
    bit ok;
    int n;
    line0 = 128'h41_44_44_00_52_31_00_2B_00_52_32_3A;
    line1 = '0; line2 = '0; line3 = '0;
    wr_q.delete();
    pulse_refresh();
    wait_writes(68, 3000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL frame_timeout: saw %0d writes, required 68", wr_q.size());
    end else begin
      for (int l = 0; l < 4; l++) begin
        checks++;
        if (wr_q[l*17] !== {1'b0, addr_exp[l]}) begin
          errors++;
          $display("FAIL frame_addr%0d: rs/data=%h, required %h", l, wr_q[l*17], {1'b0, addr_exp[l]});
        end
        for (int c = 0; c < 16; c++) begin
          checks++;
          if (wr_q[l*17+1+c] !== {1'b1, (l == 0) ? line0_exp[c] : 8'h20}) begin
            errors++;
            $display("FAIL frame_char l%0d c%0d: rs/data=%h, required %h", l, c,
                     wr_q[l*17+1+c], {1'b1, (l == 0) ? line0_exp[c] : 8'h20});
          end
        end
      end
    end
    wait_idle(200, n);
    repeat (30) @(negedge clk);
    checks++;
    if (n != 68 || wr_q.size() != 68 || busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_len: writes at idle=%0d total=%0d busy=%b, required 68 68 0",
               n, wr_q.size(), busy);
    end
  endtask

  task automatic test_snapshot();
    bit ok;
    int n;
    line0 = '0; line1 = '0; line3 = '0;
    line2 = 128'h61_62_63_64_65_66_67_68_69_6A_6B_6C_6D_6E_6F_70;
    wr_q.delete();
    @(negedge clk) refresh = 1'b1;
    @(negedge clk) refresh = 1'b0;
    @(negedge clk) line2 = {16{8'h5A}};
    wait_writes(68, 3000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL snap_timeout: saw %0d writes, required 68", wr_q.size());
    end else begin
      checks++;
      if (wr_q[34] !== 9'h090) begin
        errors++;
        $display("FAIL snap_addr: rs/data=%h, required 090", wr_q[34]);
      end
      for (int c = 0; c < 16; c++) begin
        checks++;
        if (wr_q[35+c] !== {1'b1, 8'h61 + 8'(c)}) begin
          errors++;
          $display("FAIL snap_char c%0d: rs/data=%h, required %h", c, wr_q[35+c], {1'b1, 8'h61 + 8'(c)});
        end
      end
    end
    wait_idle(200, n);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    line0 = {16{8'h31}}; line1 = '0; line2 = '0; line3 = '0;
    wr_q.delete();
    pulse_refresh();
    wait_writes(5, 500, ok);
    pulse_refresh();
    repeat (20) @(negedge clk);
    pulse_refresh();
    wait_idle(6000, n);
    repeat (50) @(negedge clk);
    checks++;
    if (n != 136 || wr_q.size() != 136) begin
      errors++;
      $display("FAIL pending_frames: writes at first idle=%0d total=%0d, required 136 136", n, wr_q.size());
    end else begin
      checks++;
      if (wr_q[68] !== 9'h080 || wr_q[69] !== 9'h131) begin
        errors++;
        $display("FAIL pending_restart: writes 68/69=%h %h, required 080 131", wr_q[68], wr_q[69]);
      end
    end
  endtask

  task automatic test_powerup_refresh();
    int n;
    rst = 1'b1;
    @(negedge clk);
    wr_q.delete();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    pulse_refresh();
    wait_idle(6000, n);
    checks++;
    if (n != 72 || init_done !== 1'b1) begin
      errors++;
      $display("FAIL powerup_pending: writes at first idle=%0d init_done=%b, required 72 1", n, init_done);
    end else begin
      checks++;
      if (wr_q[3] !== 9'h001 || wr_q[4] !== 9'h080 || wr_q[5] !== 9'h131) begin
        errors++;
        $display("FAIL powerup_seq: writes 3/4/5=%h %h %h, required 001 080 131", wr_q[3], wr_q[4], wr_q[5]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    int bad;
    wr_q.delete();
    pulse_refresh();
    wait_writes(3, 500, ok);
    for (int k = 0; k < 100 && lcd.lcd_en !== 1'b1; k++) @(negedge clk);
    checks++;
    if (!ok || lcd.lcd_en !== 1'b1 || lcd.lcd_rs !== 1'b1) begin
      errors++;
      $display("FAIL midreset_setup: ok=%b en=%b rs=%b, required 1 1 1", ok, lcd.lcd_en, lcd.lcd_rs);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (lcd.lcd_en !== 1'b0 || busy !== 1'b1 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: en=%b busy=%b init_done=%b, required 0 1 0", lcd.lcd_en, busy, init_done);
    end
    repeat (2) @(negedge clk);
    wr_q.delete();
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (lcd.lcd_en !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midreset_wait: %0d of 20 clocks had E high, required 0", bad);
    end
    wait_writes(1, 100, ok);
    checks++;
    if (!ok || wr_q[0] !== 9'h038) begin
      errors++;
      $display("FAIL midreset_first: ok=%b first write=%h, required 1 038", ok, ok ? wr_q[0] : 9'h000);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_snapshot();
    test_back_to_back();
    test_powerup_refresh();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
